// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-port memory arbiter
// Contents: state_t (IDLE, CPU_RD, EXT_RD) arbiter FSM states; req_t (REQ_CPU, REQ_EXT) requester identity.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, CPU_RD, EXT_RD} state_t;
    typedef enum logic {REQ_CPU, REQ_EXT} req_t;
endpackage

// File: rtl/mem_arbiter_rr2.sv
// mem_arbiter_rr2: combinational two-way round-robin grant
// Ports: req[0]=cpu, req[1]=ext; last_winner = previous grantee; gnt = one-hot grant (or zero when idle).
module mem_arbiter_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_t       last_winner,
    output logic [1:0] gnt
);
    always_comb gnt = &req ? (last_winner == REQ_EXT ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered-output single-port RAM between the CPU data port and an external requester
// Ports: clk/reset (async, active-high); cpu_* CPU port with cpu_stall; ext_* external port with ext_gnt;
//        ram_* RAM interface (q arrives one cycle after the address); stall_cnt contention counter.
// Build option: define MEM_ARBITER_STATS_EN to enable stall_cnt, otherwise it is tied to zero.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stall_cnt
);
    state_t            state, state_nx;
    req_t              last_winner;
    logic [1:0]        rr_gnt, gnt;
    logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

    mem_arbiter_rr2 u_rr (.req({ext_req, cpu_req}), .last_winner(last_winner), .gnt(rr_gnt));

    always_comb begin
        gnt        = state == IDLE ? rr_gnt : 2'b00;
        ram_addr   = gnt[1] ? ext_addr : cpu_addr;
        ram_wdata  = gnt[1] ? ext_wdata : cpu_wdata;
        ram_we     = !reset && ((gnt[0] && cpu_we) || (gnt[1] && ext_we));
        ext_gnt    = gnt[1];
        cpu_stall  = cpu_req && !((gnt[0] && cpu_we) || state == CPU_RD);
        cpu_rvalid = state == CPU_RD;
        ext_rvalid = state == EXT_RD;
        // read data is passed straight through in the return cycle and held afterwards
        cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
        ext_rdata  = ext_rvalid ? ram_rdata : ext_rdata_q;
        state_nx   = gnt[0] && !cpu_we ? CPU_RD : gnt[1] && !ext_we ? EXT_RD : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= REQ_EXT;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (|gnt) last_winner <= gnt[1] ? REQ_EXT : REQ_CPU;
            if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
            if (ext_rvalid) ext_rdata_q <= ram_rdata;
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (cpu_req && gnt[1] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    logic        clk = 0, reset = 1;
    logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
    logic        cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, ram_we;
    logic [31:0] cpu_rdata, ext_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [15:0] stall_cnt;
    logic [31:0] ram [0:63];
    int          n_tests = 0, n_fail = 0;

    // model state: owner of a read awaiting its data (0 none, 1 cpu, 2 ext)
    int          pend;
    logic [31:0] pend_addr;
    bit          last_ext;
    logic [31:0] exp_mem [int];
    logic [31:0] m_cpu_rd, m_ext_rd;
    int          m_cnt;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr[5:0]] <= ram_wdata;
        ram_rdata <= ram[ram_addr[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 32'h0;
    endfunction

    task automatic model_reset();
        pend = 0; last_ext = 1; m_cpu_rd = 0; m_ext_rd = 0; m_cnt = 0;
    endtask

    // one clock cycle: drive inputs, then check outputs at the falling edge and advance the model
    task automatic cycle(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit er, input bit ew, input logic [31:0] ea, input logic [31:0] ed);
        int win;
        @(posedge clk); #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
        @(negedge clk);
        if (pend != 0) begin
            if (pend == 1) m_cpu_rd = rd_mem(pend_addr);
            else m_ext_rd = rd_mem(pend_addr);
            check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
            check("rd_ext_rvalid", 32'(ext_rvalid), 32'(pend == 2));
            check("rd_ram_we", 32'(ram_we), 0);
            check("rd_ext_gnt", 32'(ext_gnt), 0);
            check("rd_cpu_stall", 32'(cpu_stall), 32'(cr && pend != 1));
            pend = 0;
        end else begin
            win = (cr && er) ? (last_ext ? 1 : 2) : cr ? 1 : er ? 2 : 0;
            check("cpu_rvalid", 32'(cpu_rvalid), 0);
            check("ext_rvalid", 32'(ext_rvalid), 0);
            check("ext_gnt", 32'(ext_gnt), 32'(win == 2));
            check("ram_we", 32'(ram_we), 32'((win == 1 && cw) || (win == 2 && ew)));
            check("cpu_stall", 32'(cpu_stall), 32'(cr && !(win == 1 && cw)));
            if (win != 0) begin
                check("ram_addr", ram_addr, win == 1 ? ca : ea);
                if ((win == 1) ? cw : ew) begin
                    check("ram_wdata", ram_wdata, win == 1 ? cd : ed);
                    exp_mem[int'(win == 1 ? ca : ea)] = win == 1 ? cd : ed;
                end else begin
                    pend = win;
                    pend_addr = win == 1 ? ca : ea;
                end
                last_ext = win == 2;
            end
`ifdef MEM_ARBITER_STATS_EN
            if (cr && win == 2 && m_cnt < 65535) m_cnt++;
`endif
        end
        check("cpu_rdata", cpu_rdata, m_cpu_rd);
        check("ext_rdata", ext_rdata, m_ext_rd);
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 0;
        model_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ram_we", 32'(ram_we), 0);
        check("reset_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("reset_ext_rvalid", 32'(ext_rvalid), 0);
        check("reset_cpu_rdata", cpu_rdata, 0);
        check("reset_ext_rdata", ext_rdata, 0);
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        cpu_req = 0; cpu_we = 0;
        @(posedge clk); #1 reset = 0;
        // both read on the first cycle out of reset: cpu first, ext afterwards
        cycle(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h8, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h8, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // cpu write then read back
        cycle(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
        check("readback", cpu_rdata, 32'hDEADBEEF);
        // contended writes alternate
        for (int i = 0; i < 4; i++) cycle(1, 1, 32'(i), 32'(100 + i), 1, 1, 32'(i + 8), 32'(200 + i));
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a cpu read: no return afterwards
        cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
        cpu_req = 0;
        @(posedge clk); #1 reset = 1;
        #1;
        check("midrd_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("midrd_cpu_rdata", cpu_rdata, 0);
        check("midrd_stall_cnt", 32'(stall_cnt), 0);
        @(posedge clk); #1 reset = 0;
        model_reset();
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 31)), $urandom);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
